pipe_stage_skid: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the 16-bit core (ID/EX, EX/MEM, MEM/WB).
- Replaces plain enable-gated stage registers with a valid/ready handshake, optional 2-entry skid buffer, hazard stall and branch flush.
- Control fields are zeroed on bubbles and flushes; payload fields are held.
- One instance per stage boundary. CTRL_W/DATA_W are set per stage.

---
 rtl/pipe_stage_skid.sv | 119 +++++++++++
 tb/tb_pipe_stage_skid.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_skid                                              |
// | Description : Inter-stage pipeline register with valid/ready handshake,    |
// |               optional 2-entry skid, hazard stall and branch flush.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_skid #(
    parameter int CTRL_W  = 10,
    parameter int DATA_W  = 112,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;

    logic w_out_valid;
    logic w_in_ready;
    logic w_skid_valid;
    logic w_acc;
    logic w_drn;

    // Stall hides the held beat from downstream, so no handshake can complete.
    assign w_out_valid = r_main_valid & ~stall;
    assign w_acc       = in_valid & w_in_ready;
    assign w_drn       = w_out_valid & out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
    assign out_data  = r_main_data;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, w_skid_valid};

    generate
        if (SKID_EN != 0) begin : g_skid
            logic              r_skid_valid;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            // Registered ready: no combinational path from out_ready.
            assign w_in_ready   = ~r_skid_valid & ~stall;
            assign w_skid_valid = r_skid_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_main_valid <= 1'b0;
                    r_main_ctrl  <= '0;
                    r_main_data  <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_skid_data  <= '0;
                end else if (flush) begin
                    r_main_valid <= 1'b0;
                    r_main_ctrl  <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                end else if (!r_main_valid) begin
                    if (w_acc) begin
                        r_main_valid <= 1'b1;
                        r_main_ctrl  <= in_ctrl;
                        r_main_data  <= in_data;
                    end
                end else if (r_skid_valid) begin
                    if (w_drn) begin
                        r_main_ctrl  <= r_skid_ctrl;
                        r_main_data  <= r_skid_data;
                        r_skid_valid <= 1'b0;
                    end
                end else if (w_acc && w_drn) begin
                    r_main_ctrl <= in_ctrl;
                    r_main_data <= in_data;
                end else if (w_acc) begin
                    r_skid_valid <= 1'b1;
                    r_skid_ctrl  <= in_ctrl;
                    r_skid_data  <= in_data;
                end else if (w_drn) begin
                    r_main_valid <= 1'b0;
                end
            end
        end else begin : g_noskid
            assign w_in_ready   = (~r_main_valid | out_ready) & ~stall;
            assign w_skid_valid = 1'b0;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_main_valid <= 1'b0;
                    r_main_ctrl  <= '0;
                    r_main_data  <= '0;
                end else if (flush) begin
                    r_main_valid <= 1'b0;
                    r_main_ctrl  <= '0;
                end else if (w_acc) begin
                    r_main_valid <= 1'b1;
                    r_main_ctrl  <= in_ctrl;
                    r_main_data  <= in_data;
                end else if (w_drn) begin
                    r_main_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_skid                                           |
// | Description : Scoreboard bench for pipe_stage_skid, skid and non-skid.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_skid;

    localparam int CW = 10;
    localparam int DW = 112;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic          a_in_valid = 1'b0, a_out_ready = 1'b0, a_stall = 1'b0, a_flush = 1'b0;
    logic [CW-1:0] a_in_ctrl = '0;
    logic [DW-1:0] a_in_data = '0;
    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_occ;

    logic          b_in_valid = 1'b0, b_out_ready = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
    logic [CW-1:0] b_in_ctrl = '0;
    logic [DW-1:0] b_in_data = '0;
    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_occ;

    int    total = 0;
    int    bad   = 0;
    logic  b_active = 1'b0;
    beat_t qa[$];
    beat_t qb[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .stall(a_stall), .flush(a_flush), .occupancy(a_occ)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .stall(b_stall), .flush(b_flush), .occupancy(b_occ)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the skid instance: push on accept, pop on drain.
    always @(negedge clk) begin : mon_a
        beat_t e;
        if (reset || a_flush) begin
            qa.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                total = total + 1;
                if (qa.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL sb_a: unexpected beat data=%0h, expected none", a_out_data);
                end else begin
                    e = qa.pop_front();
                    if (a_out_ctrl !== e.c || a_out_data !== e.d) begin
                        bad = bad + 1;
                        $display("FAIL sb_a: got ctrl=%0h data=%0h expected ctrl=%0h data=%0h",
                                 a_out_ctrl, a_out_data, e.c, e.d);
                    end
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back('{c: a_in_ctrl, d: a_in_data});
        end
    end

    always @(negedge clk) begin : mon_b
        beat_t e;
        if (reset || b_flush) begin
            qb.delete();
        end else begin
            if (b_active) begin
                check("b_occ_le1", 128'(b_occ <= 2'd1), 128'(1));
                check("b_in_ready", 128'(b_in_ready), 128'(!b_out_valid || b_out_ready));
            end
            if (b_out_valid && b_out_ready) begin
                total = total + 1;
                if (qb.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL sb_b: unexpected beat data=%0h, expected none", b_out_data);
                end else begin
                    e = qb.pop_front();
                    if (b_out_ctrl !== e.c || b_out_data !== e.d) begin
                        bad = bad + 1;
                        $display("FAIL sb_b: got ctrl=%0h data=%0h expected ctrl=%0h data=%0h",
                                 b_out_ctrl, b_out_data, e.c, e.d);
                    end
                end
            end
            if (b_in_valid && b_in_ready) qb.push_back('{c: b_in_ctrl, d: b_in_data});
        end
    end

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_out_ctrl", 128'(a_out_ctrl), 128'(0));
        check("rst_out_data", 128'(a_out_data), 128'(0));
        check("rst_occ", 128'(a_occ), 128'(0));
        check("rst_in_ready", 128'(a_in_ready), 128'(1));
        check("rst_b_in_ready", 128'(b_in_ready), 128'(1));

        // 1: streaming, one-cycle latency
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_ctrl   = 10'h3FF;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = DW'(i);
            #1;
            check("t1_in_ready", 128'(a_in_ready), 128'(1));
            if (i == 1) check("t1_first_out_valid", 128'(a_out_valid), 128'(0));
            tick();
            check("t1_out_valid", 128'(a_out_valid), 128'(1));
            check("t1_out_data", 128'(a_out_data), 128'(i));
            check("t1_out_ctrl", 128'(a_out_ctrl), 128'(10'h3FF));
            check("t1_occ", 128'(a_occ), 128'(1));
        end
        a_in_valid = 1'b0;
        tick();
        check("t1_empty_occ", 128'(a_occ), 128'(0));
        check("t1_empty_ctrl", 128'(a_out_ctrl), 128'(0));

        // 2: backpressure fills the skid entry
        a_in_valid = 1'b1; a_in_ctrl = 10'h2A1; a_in_data = DW'(32'hA);
        tick();
        a_out_ready = 1'b0; a_in_ctrl = 10'h2B2; a_in_data = DW'(32'hB);
        tick();
        check("t2_occ2", 128'(a_occ), 128'(2));
        check("t2_in_ready0", 128'(a_in_ready), 128'(0));
        check("t2_hold_a", 128'(a_out_data), 128'(32'hA));
        a_in_ctrl = 10'h2C3; a_in_data = DW'(32'hC);
        tick();
        check("t2_still_occ2", 128'(a_occ), 128'(2));
        check("t2_still_a", 128'(a_out_data), 128'(32'hA));
        a_out_ready = 1'b1;
        tick();
        check("t2_b_next", 128'(a_out_data), 128'(32'hB));
        check("t2_b_valid", 128'(a_out_valid), 128'(1));
        check("t2_occ1", 128'(a_occ), 128'(1));
        check("t2_in_ready1", 128'(a_in_ready), 128'(1));
        tick();
        check("t2_c_next", 128'(a_out_data), 128'(32'hC));
        check("t2_c_ctrl", 128'(a_out_ctrl), 128'(10'h2C3));
        a_in_valid = 1'b0;
        tick();
        check("t2_drained", 128'(a_occ), 128'(0));

        // 3: stall freezes contents and bubbles ctrl
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 10'h155; a_in_data = DW'(32'h77);
        tick();
        a_in_valid = 1'b0; a_stall = 1'b1; a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_out_valid", 128'(a_out_valid), 128'(0));
            check("t3_out_ctrl", 128'(a_out_ctrl), 128'(0));
            check("t3_out_data", 128'(a_out_data), 128'(32'h77));
            check("t3_in_ready", 128'(a_in_ready), 128'(0));
            check("t3_occ", 128'(a_occ), 128'(1));
            tick();
        end
        a_stall = 1'b0;
        #1;
        check("t3_resume_valid", 128'(a_out_valid), 128'(1));
        check("t3_resume_ctrl", 128'(a_out_ctrl), 128'(10'h155));
        tick();
        check("t3_drained", 128'(a_occ), 128'(0));

        // 4: flush with two held beats, then flush of an accepted beat
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 10'h0F1; a_in_data = DW'(32'h1A1);
        tick();
        a_in_ctrl = 10'h0F2; a_in_data = DW'(32'h1B2);
        tick();
        check("t4_occ2", 128'(a_occ), 128'(2));
        a_in_ctrl = 10'h0F3; a_in_data = DW'(32'h1C3); a_flush = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("t4_occ0", 128'(a_occ), 128'(0));
        check("t4_out_valid", 128'(a_out_valid), 128'(0));
        check("t4_out_ctrl", 128'(a_out_ctrl), 128'(0));
        check("t4_out_data", 128'(a_out_data), 128'(32'h1A1));
        a_in_valid = 1'b1; a_in_ctrl = 10'h0F4; a_in_data = DW'(32'h1D4); a_flush = 1'b1;
        #1;
        check("t4_flush_in_ready", 128'(a_in_ready), 128'(1));
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("t4_discard_occ", 128'(a_occ), 128'(0));
        check("t4_discard_data", 128'(a_out_data), 128'(32'h1A1));
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_ctrl = 10'h0F5; a_in_data = DW'(32'h1E5);
        tick();
        a_in_valid = 1'b0;
        check("t4_post_data", 128'(a_out_data), 128'(32'h1E5));
        tick();

        // 5: reset while full and stalled
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 10'h011; a_in_data = DW'(32'h21);
        tick();
        a_in_data = DW'(32'h22);
        tick();
        check("t5_occ2", 128'(a_occ), 128'(2));
        a_in_valid = 1'b0; a_stall = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; a_stall = 1'b0;
        #1;
        check("t5_out_valid", 128'(a_out_valid), 128'(0));
        check("t5_out_ctrl", 128'(a_out_ctrl), 128'(0));
        check("t5_out_data", 128'(a_out_data), 128'(0));
        check("t5_occ", 128'(a_occ), 128'(0));
        check("t5_in_ready", 128'(a_in_ready), 128'(1));
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_ctrl = 10'h101; a_in_data = DW'(32'h55);
        tick();
        a_in_valid = 1'b0;
        check("t5_post_data", 128'(a_out_data), 128'(32'h55));
        check("t5_post_ctrl", 128'(a_out_ctrl), 128'(10'h101));
        tick();

        // 6: non-skid build under random valid/ready
        b_active = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_ctrl   = CW'($urandom);
            b_in_data   = DW'({$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick(); tick(); tick();
        b_active = 1'b0;
        check("end_qa_empty", 128'(qa.size()), 128'(0));
        check("end_qb_empty", 128'(qb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
